// File: rtl/pc_fetch.sv
// pc_fetch: PC generation and instruction-fetch stage feeding the IF/ID register.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirect targets (HALT + if_excpt_adel).
module pc_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ack,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              stallreq_if
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic              if_excpt_adel
`endif
);

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    FETCH   = 3'd1,
    HOLD    = 3'd2,
    DISCARD = 3'd3,
    HALT    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    FETCH   = 3'd1,
    HOLD    = 3'd2,
    DISCARD = 3'd3
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);
  localparam logic [ADDR_W-1:0] ZERO_A  = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_D  = {DATA_W{1'b0}};

  state_t            state_r, state_n;
  logic [ADDR_W-1:0] pc_r, pc_n;
  logic [ADDR_W-1:0] disc_addr_r, disc_addr_n;
  logic [ADDR_W-1:0] buf_pc_r, buf_pc_n;
  logic [DATA_W-1:0] buf_inst_r, buf_inst_n;
  logic              buf_valid_r, buf_valid_n;
  logic [ADDR_W-1:0] if_pc_n;
  logic [DATA_W-1:0] if_inst_n;
  logic              hold_s;
  logic              ack_s;
  logic              redirect_s;
  logic [ADDR_W-1:0] flush_tgt_s;
  logic [ADDR_W-1:0] branch_tgt_s;
`ifdef PC_ALIGN_CHECK_EN
  logic              adel_n;
`endif

  function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] t);
`ifdef PC_ALIGN_CHECK_EN
    align_target = t;
`else
    align_target = {t[ADDR_W-1:2], 2'b00};
`endif
  endfunction

`ifdef PC_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [ADDR_W-1:0] t);
    misaligned = (t[1:0] != 2'b00);
  endfunction

  logic unused_s;
  assign unused_s = ^stall[5:1];
`else
  logic unused_s;
  assign unused_s = ^{stall[5:1], new_pc[1:0], branch_target_i[1:0]};
`endif

  // Handshake outputs; DISCARD keeps presenting the abandoned address until its ack.
  assign inst_req     = (state_r == FETCH) || (state_r == DISCARD);
  assign inst_addr    = (state_r == DISCARD) ? disc_addr_r : pc_r;
  assign stallreq_if  = inst_req & ~inst_ack;
  assign hold_s       = stall[0];
  assign ack_s        = inst_ack & inst_req;
  assign redirect_s   = branch_flag_i & ~hold_s;
  assign flush_tgt_s  = align_target(new_pc);
  assign branch_tgt_s = align_target(branch_target_i);

  // Next-state, PC, buffer and output-register logic.
  always_comb begin
    state_n     = state_r;
    pc_n        = pc_r;
    disc_addr_n = disc_addr_r;
    buf_pc_n    = buf_pc_r;
    buf_inst_n  = buf_inst_r;
    buf_valid_n = buf_valid_r;
    if_pc_n     = if_pc;
    if_inst_n   = if_inst;
`ifdef PC_ALIGN_CHECK_EN
    adel_n      = if_excpt_adel;
`endif
    if (flush) begin
      pc_n        = flush_tgt_s;
      if_pc_n     = ZERO_A;
      if_inst_n   = ZERO_D;
      buf_valid_n = 1'b0;
      disc_addr_n = inst_addr;
      if (inst_req && !inst_ack) begin
        state_n = DISCARD;
      end else begin
        state_n = FETCH;
      end
`ifdef PC_ALIGN_CHECK_EN
      if (misaligned(new_pc)) begin
        state_n = HALT;
        if_pc_n = new_pc;
        adel_n  = 1'b1;
      end else begin
        adel_n  = 1'b0;
      end
`endif
    end else begin
      case (state_r)
        BOOT: begin
          state_n = FETCH;
          if (redirect_s) begin
            pc_n = branch_tgt_s;
          end else begin
            pc_n = pc_r;
          end
          if (!hold_s) begin
            if_pc_n   = ZERO_A;
            if_inst_n = ZERO_D;
          end else begin
            if_pc_n   = if_pc;
            if_inst_n = if_inst;
          end
        end
        FETCH: begin
          if (redirect_s) begin
            // Same-cycle data is wrong-path; an unacked request must still be drained.
            pc_n        = branch_tgt_s;
            if_pc_n     = ZERO_A;
            if_inst_n   = ZERO_D;
            disc_addr_n = pc_r;
            if (ack_s) begin
              state_n = FETCH;
            end else begin
              state_n = DISCARD;
            end
          end else if (ack_s) begin
            pc_n = pc_r + PC_STEP;
            if (!hold_s) begin
              if_pc_n   = pc_r;
              if_inst_n = inst_rdata;
            end else begin
              buf_pc_n    = pc_r;
              buf_inst_n  = inst_rdata;
              buf_valid_n = 1'b1;
              state_n     = HOLD;
            end
          end else begin
            if (!hold_s) begin
              if_pc_n   = ZERO_A;
              if_inst_n = ZERO_D;
            end else begin
              if_pc_n   = if_pc;
              if_inst_n = if_inst;
            end
          end
        end
        HOLD: begin
          if (!hold_s) begin
            state_n     = FETCH;
            buf_valid_n = 1'b0;
            if (buf_valid_r) begin
              if_pc_n   = buf_pc_r;
              if_inst_n = buf_inst_r;
            end else begin
              if_pc_n   = ZERO_A;
              if_inst_n = ZERO_D;
            end
            if (branch_flag_i) begin
              pc_n = branch_tgt_s;
            end else begin
              pc_n = pc_r;
            end
          end else begin
            state_n = HOLD;
          end
        end
        DISCARD: begin
          if (redirect_s) begin
            pc_n = branch_tgt_s;
          end else begin
            pc_n = pc_r;
          end
          if (ack_s) begin
            state_n = FETCH;
          end else begin
            state_n = DISCARD;
          end
          if (!hold_s) begin
            if_pc_n   = ZERO_A;
            if_inst_n = ZERO_D;
          end else begin
            if_pc_n   = if_pc;
            if_inst_n = if_inst;
          end
        end
`ifdef PC_ALIGN_CHECK_EN
        HALT: begin
          state_n = HALT;
        end
`endif
        default: begin
          state_n     = BOOT;
          pc_n        = RESET_PC;
          if_pc_n     = ZERO_A;
          if_inst_n   = ZERO_D;
          buf_valid_n = 1'b0;
        end
      endcase
`ifdef PC_ALIGN_CHECK_EN
      // A misaligned branch target traps instead of fetching.
      if (redirect_s && (state_r != HALT) && misaligned(branch_target_i)) begin
        state_n     = HALT;
        pc_n        = branch_target_i;
        if_pc_n     = branch_target_i;
        if_inst_n   = ZERO_D;
        buf_valid_n = 1'b0;
        adel_n      = 1'b1;
      end else begin
        adel_n      = if_excpt_adel;
      end
`endif
    end
  end

  // State, PC, skid buffer and IF/ID-facing output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= BOOT;
      pc_r        <= RESET_PC;
      disc_addr_r <= ZERO_A;
      buf_pc_r    <= ZERO_A;
      buf_inst_r  <= ZERO_D;
      buf_valid_r <= 1'b0;
      if_pc       <= ZERO_A;
      if_inst     <= ZERO_D;
`ifdef PC_ALIGN_CHECK_EN
      if_excpt_adel <= 1'b0;
`endif
    end else begin
      state_r     <= state_n;
      pc_r        <= pc_n;
      disc_addr_r <= disc_addr_n;
      buf_pc_r    <= buf_pc_n;
      buf_inst_r  <= buf_inst_n;
      buf_valid_r <= buf_valid_n;
      if_pc       <= if_pc_n;
      if_inst     <= if_inst_n;
`ifdef PC_ALIGN_CHECK_EN
      if_excpt_adel <= adel_n;
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: scripted memory responses with a scoreboard of expected IF/ID outputs.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = 6'b000000;
  logic        flush = 1'b0;
  logic [31:0] new_pc = 32'h0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rdata(inst_rdata), .if_pc(if_pc), .if_inst(if_inst),
    .stallreq_if(stallreq_if)
  );

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    inst_ack = 1'b0; stall = 6'b0; flush = 1'b0; branch_flag_i = 1'b0;
    rst = 1'b0;
    wait_edge();
    rst = 1'b1;
    wait_edge();
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) wait_edge();
    checks++;
    if (inst_req !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0 || stallreq_if !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req=%b pc=%h inst=%h sreq=%b expected 0/0/0/0", inst_req, if_pc, if_inst, stallreq_if);
    end
    rst = 1'b1;
    wait_edge();
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h0 || stallreq_if !== 1'b1) begin
      errors++;
      $display("FAIL boot_req: req=%b addr=%h sreq=%b expected 1/00000000/1", inst_req, inst_addr, stallreq_if);
    end
  endtask

  task automatic test_seq();
    logic [31:0] data [3];
    data[0] = 32'h3401_0001; data[1] = 32'h3402_0002; data[2] = 32'h3403_0003;
    for (int i = 0; i < 3; i++) begin
      inst_ack = 1'b1; inst_rdata = data[i];
      sb.push_back({32'(i * 4), data[i]});
      #1;
      checks++;
      if (inst_addr !== 32'(i * 4) || stallreq_if !== 1'b0) begin
        errors++;
        $display("FAIL seq_req: addr=%h sreq=%b expected %h/0", inst_addr, stallreq_if, 32'(i * 4));
      end
      wait_edge();
      checks++;
      e = sb.pop_front();
      if (if_pc !== e.pc || if_inst !== e.inst) begin
        errors++;
        $display("FAIL seq_out: pc=%h inst=%h expected %h/%h", if_pc, if_inst, e.pc, e.inst);
      end
    end
    inst_ack = 1'b0;
    wait_edge();
    checks++;
    if (if_pc !== 32'h0 || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL seq_bubble: pc=%h inst=%h expected 0/0", if_pc, if_inst);
    end
  endtask

  task automatic test_slow();
    do_reset();
    inst_ack = 1'b1; inst_rdata = 32'h3401_0001;
    sb.push_back({32'h0, 32'h3401_0001});
    wait_edge();
    checks++;
    e = sb.pop_front();
    if (if_pc !== e.pc || if_inst !== e.inst) begin
      errors++;
      $display("FAIL slow_first: pc=%h inst=%h expected %h/%h", if_pc, if_inst, e.pc, e.inst);
    end
    inst_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (inst_addr !== 32'h4 || stallreq_if !== 1'b1 || inst_req !== 1'b1) begin
        errors++;
        $display("FAIL slow_wait_req: addr=%h sreq=%b req=%b expected 00000004/1/1", inst_addr, stallreq_if, inst_req);
      end
      wait_edge();
      checks++;
      if (if_inst !== 32'h0 || if_pc !== 32'h0) begin
        errors++;
        $display("FAIL slow_wait_bubble: pc=%h inst=%h expected 0/0", if_pc, if_inst);
      end
    end
    inst_ack = 1'b1; inst_rdata = 32'h3402_0002;
    sb.push_back({32'h4, 32'h3402_0002});
    #1;
    checks++;
    if (stallreq_if !== 1'b0) begin
      errors++;
      $display("FAIL slow_ack_sreq: sreq=%b expected 0", stallreq_if);
    end
    wait_edge();
    checks++;
    e = sb.pop_front();
    if (if_pc !== e.pc || if_inst !== e.inst) begin
      errors++;
      $display("FAIL slow_out: pc=%h inst=%h expected %h/%h", if_pc, if_inst, e.pc, e.inst);
    end
    inst_ack = 1'b0;
  endtask

  task automatic test_stall();
    stall = 6'b000001; inst_ack = 1'b1; inst_rdata = 32'hAABB_CCDD;
    #1;
    checks++;
    if (inst_addr !== 32'h8) begin
      errors++;
      $display("FAIL stall_addr: addr=%h expected 00000008", inst_addr);
    end
    wait_edge();
    inst_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (inst_req !== 1'b0 || if_pc !== 32'h4 || if_inst !== 32'h3402_0002) begin
        errors++;
        $display("FAIL stall_hold: req=%b pc=%h inst=%h expected 0/00000004/34020002", inst_req, if_pc, if_inst);
      end
      if (k < 2) wait_edge();
    end
    stall = 6'b000000;
    sb.push_back({32'h8, 32'hAABB_CCDD});
    wait_edge();
    checks++;
    e = sb.pop_front();
    if (if_pc !== e.pc || if_inst !== e.inst || inst_req !== 1'b1 || inst_addr !== 32'hC) begin
      errors++;
      $display("FAIL stall_release: pc=%h inst=%h req=%b addr=%h expected %h/%h/1/0000000c", if_pc, if_inst, inst_req, inst_addr, e.pc, e.inst);
    end
  endtask

  task automatic test_branch();
    branch_flag_i = 1'b1; branch_target_i = 32'h0000_0100;
    #1;
    checks++;
    if (stallreq_if !== 1'b1) begin
      errors++;
      $display("FAIL branch_sreq: sreq=%b expected 1", stallreq_if);
    end
    wait_edge();
    branch_flag_i = 1'b0;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hC || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL branch_discard: req=%b addr=%h inst=%h expected 1/0000000c/0", inst_req, inst_addr, if_inst);
    end
    inst_ack = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    wait_edge();
    inst_ack = 1'b0;
    checks++;
    if (if_inst !== 32'h0 || inst_addr !== 32'h100 || inst_req !== 1'b1) begin
      errors++;
      $display("FAIL branch_drop: inst=%h addr=%h req=%b expected 0/00000100/1", if_inst, inst_addr, inst_req);
    end
    // Same-cycle ack is wrong-path; misaligned target is rounded down.
    inst_ack = 1'b1; inst_rdata = 32'h1111_1111;
    branch_flag_i = 1'b1; branch_target_i = 32'h0000_0203;
    wait_edge();
    branch_flag_i = 1'b0; inst_ack = 1'b0;
    checks++;
    if (if_inst !== 32'h0 || inst_addr !== 32'h200) begin
      errors++;
      $display("FAIL branch_align: inst=%h addr=%h expected 0/00000200", if_inst, inst_addr);
    end
    inst_ack = 1'b1; inst_rdata = 32'h2222_2222;
    sb.push_back({32'h200, 32'h2222_2222});
    wait_edge();
    inst_ack = 1'b0;
    checks++;
    e = sb.pop_front();
    if (if_pc !== e.pc || if_inst !== e.inst) begin
      errors++;
      $display("FAIL branch_target_out: pc=%h inst=%h expected %h/%h", if_pc, if_inst, e.pc, e.inst);
    end
  endtask

  task automatic test_flush();
    stall = 6'b000001; flush = 1'b1; new_pc = 32'h0000_0180;
    inst_ack = 1'b1; inst_rdata = 32'h3333_3333;
    branch_flag_i = 1'b1; branch_target_i = 32'h0000_0300;
    wait_edge();
    flush = 1'b0; inst_ack = 1'b0;
    checks++;
    if (if_inst !== 32'h0 || if_pc !== 32'h0 || inst_req !== 1'b1 || inst_addr !== 32'h180) begin
      errors++;
      $display("FAIL flush_stall: pc=%h inst=%h req=%b addr=%h expected 0/0/1/00000180", if_pc, if_inst, inst_req, inst_addr);
    end
    wait_edge();
    checks++;
    if (inst_addr !== 32'h180 || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL branch_ignored_stall: addr=%h inst=%h expected 00000180/0", inst_addr, if_inst);
    end
    stall = 6'b000000; branch_flag_i = 1'b0;
    inst_ack = 1'b1; inst_rdata = 32'h4444_4444;
    sb.push_back({32'h180, 32'h4444_4444});
    wait_edge();
    inst_ack = 1'b0;
    checks++;
    e = sb.pop_front();
    if (if_pc !== e.pc || if_inst !== e.inst) begin
      errors++;
      $display("FAIL flush_target_out: pc=%h inst=%h expected %h/%h", if_pc, if_inst, e.pc, e.inst);
    end
  endtask

  task automatic test_wrap();
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    wait_edge();
    flush = 1'b0;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h184) begin
      errors++;
      $display("FAIL flush_discard: req=%b addr=%h expected 1/00000184", inst_req, inst_addr);
    end
    inst_ack = 1'b1; inst_rdata = 32'h5555_5555;
    wait_edge();
    inst_rdata = 32'h6666_6666;
    sb.push_back({32'hFFFF_FFFC, 32'h6666_6666});
    wait_edge();
    inst_ack = 1'b0;
    checks++;
    e = sb.pop_front();
    if (if_pc !== e.pc || if_inst !== e.inst || inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap: pc=%h inst=%h addr=%h expected %h/%h/00000000", if_pc, if_inst, inst_addr, e.pc, e.inst);
    end
  endtask

  task automatic test_reset_mid();
    inst_ack = 1'b1; inst_rdata = 32'h7777_7777;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (inst_req !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0 || stallreq_if !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: req=%b pc=%h inst=%h sreq=%b expected 0/0/0/0", inst_req, if_pc, if_inst, stallreq_if);
    end
    inst_ack = 1'b0;
    wait_edge();
    rst = 1'b1;
    wait_edge();
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_reboot: req=%b addr=%h expected 1/00000000", inst_req, inst_addr);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_slow();
    test_stall();
    test_branch();
    test_flush();
    test_wrap();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
